// File: rtl/octant_normalize_if.sv
// Segment request / normalized result handshake bundle for octant_normalize.
interface octant_normalize_if #(
  parameter int XW = 8,
  parameter int YW = 7
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [XW-1:0]        dx;
  logic [YW-1:0]        dy;
  logic                 out_valid;
  logic                 out_ready;
  logic                 flip_x;
  logic                 flip_y;
  logic                 flip_identity;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;
  logic signed [XW+1:0] err0;
  logic                 degenerate;

  modport master (
    output in_valid, dx, dy, out_ready,
    input  in_ready, out_valid, flip_x, flip_y, flip_identity, nx, ny, err0, degenerate
  );

  modport slave (
    input  in_valid, dx, dy, out_ready,
    output in_ready, out_valid, flip_x, flip_y, flip_identity, nx, ny, err0, degenerate
  );
endinterface

// File: rtl/octant_normalize.sv
// Folds a signed (dx,dy) segment into the first octant and emits the initial Bresenham error.
module octant_normalize #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input logic               clk,
  input logic               rst_n,
  octant_normalize_if.slave bus
);
  if (XW != YW + 1) begin : g_width_check
    $error("octant_normalize: XW must equal YW+1");
  end

  logic          s1_valid;
  logic [XW-1:0] s1_ax;
  logic [XW-1:0] s1_ay;
  logic          s1_sx;
  logic          s1_sy;
  logic          s1_advance;
  logic [XW-1:0] abs_x;
  logic [YW-1:0] abs_y;

  logic                 s2_valid;
  logic                 s2_fx;
  logic                 s2_fy;
  logic                 s2_fi;
  logic [XW-1:0]        s2_nx;
  logic [YW-1:0]        s2_ny;
  logic signed [XW+1:0] s2_err0;
  logic                 s2_deg;

  logic                 swap;
  logic [XW-1:0]        nx_d;
  logic [YW-1:0]        ny_d;
  logic signed [XW+1:0] err0_d;

  // Negating the most negative value wraps to 2^(W-1), which is exactly the magnitude as unsigned.
  always_comb begin
    abs_x = bus.dx[XW-1] ? (XW'(0) - bus.dx) : bus.dx;
    abs_y = bus.dy[YW-1] ? (YW'(0) - bus.dy) : bus.dy;
  end

  assign s1_advance   = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ax    <= '0;
      s1_ay    <= '0;
      s1_sx    <= 1'b0;
      s1_sy    <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ax <= abs_x;
        s1_ay <= XW'(abs_y);
        s1_sx <= bus.dx[XW-1];
        s1_sy <= bus.dy[YW-1];
      end
    end
  end

  // Ties keep x as the major axis; when y is major, |dx| < 2^(YW-1) so truncation is lossless.
  always_comb begin
    swap   = s1_ax < s1_ay;
    nx_d   = swap ? s1_ay : s1_ax;
    ny_d   = swap ? s1_ax[YW-1:0] : s1_ay[YW-1:0];
    err0_d = $signed({2'b00, ny_d, 1'b0}) - $signed({2'b00, nx_d});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_fx    <= 1'b0;
      s2_fy    <= 1'b0;
      s2_fi    <= 1'b0;
      s2_nx    <= '0;
      s2_ny    <= '0;
      s2_err0  <= '0;
      s2_deg   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_fx   <= s1_sx;
        s2_fy   <= s1_sy;
        s2_fi   <= swap;
        s2_nx   <= nx_d;
        s2_ny   <= ny_d;
        s2_err0 <= err0_d;
        s2_deg  <= (s1_ax == '0) && (s1_ay == '0);
      end
    end
  end

  assign bus.out_valid     = s2_valid;
  assign bus.flip_x        = s2_fx;
  assign bus.flip_y        = s2_fy;
  assign bus.flip_identity = s2_fi;
  assign bus.nx            = s2_nx;
  assign bus.ny            = s2_ny;
  assign bus.err0          = s2_err0;
  assign bus.degenerate    = s2_deg;
endmodule
